// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N-channel registered mux with fixed-select or round-robin grant and valid/ready flow control
module mux_nto1_rr #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          xfer_cnt
);
   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  ch_q, ch_d, last_q, last_d, gnt;
   logic             valid_q, valid_d, gnt_ok, load_en, xfer;
   logic [15:0]      cnt_q, cnt_d;
   // grant selection: fixed index or first valid channel after the last winner
   always_comb begin
      gnt_ok = 1'b0;
      gnt    = '0;
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (int'(last_q) + k) % NCH;
         if (mode && !gnt_ok && in_valid[c]) begin
            gnt_ok = 1'b1;
            gnt    = SELW'(c);
         end
      end
      for (int i = 0; i < NCH; i++)
         if (!mode && int'(sel) == i && in_valid[i]) begin
            gnt_ok = 1'b1;
            gnt    = SELW'(i);
         end
   end
   assign load_en  = !valid_q || out_ready;
   assign xfer     = load_en && gnt_ok && !reset;
   assign in_ready = xfer ? (NCH'(1) << gnt) : '0;
   // next state of the output stage, counter and round-robin pointer
   always_comb begin
      data_d  = xfer ? in_data[gnt*WIDTH +: WIDTH] : data_q;
      ch_d    = xfer ? gnt : ch_q;
      valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : valid_q);
      cnt_d   = xfer ? cnt_q + 16'd1 : cnt_q;
      last_d  = (xfer && mode) ? gnt : last_q;
   end
   // state registers; reset empties the output and gives channel 0 first priority
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         last_q  <= SELW'(NCH - 1);
      end else begin
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end
   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = valid_q;
   assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: vector table, directed sequences and random traffic against a reference model
module tb_mux_nto1_rr;
   localparam int NCH = 4;
   logic        clk = 0, reset, mode, out_ready, out_valid;
   logic [1:0]  sel, out_ch;
   logic [31:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [7:0]  out_data;
   logic [15:0] xfer_cnt;
   int          checks = 0, errors = 0;
   logic        m_v;
   logic [7:0]  m_d;
   int          m_ch, m_last;
   logic [15:0] m_cnt;

   mux_nto1_rr #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       ordy;
      logic [3:0] exp_ready;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void grant(output bit ok, output int g);
      ok = 0;
      g = 0;
      if (reset) return;
      if (!mode) begin
         if (int'(sel) < NCH && in_valid[sel]) begin
            ok = 1;
            g = int'(sel);
         end
      end else
         for (int k = 1; k <= NCH; k++)
            if (!ok && in_valid[(m_last + k) % NCH]) begin
               ok = 1;
               g = (m_last + k) % NCH;
            end
   endfunction

   task automatic tick();
      bit ok;
      int g;
      logic [3:0] er;
      @(negedge clk);
      grant(ok, g);
      er = (ok && (!m_v || out_ready)) ? 4'(1 << g) : 4'b0;
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (reset) begin
         m_v = 0; m_d = 0; m_ch = 0; m_cnt = 0; m_last = NCH - 1;
      end else if (er != 0) begin
         m_v = 1; m_d = in_data[g*8 +: 8]; m_ch = g; m_cnt = m_cnt + 16'd1;
         if (mode) m_last = g;
      end else if (out_ready) m_v = 0;
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_v));
      chk("out_data", 32'(out_data), 32'(m_d));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
   endtask

   initial begin
      vec_t vt[7];
      logic [15:0] c0;
      vt[0] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
      vt[1] = '{1'b1, 2'd0, 4'b1010, 1'b0, 4'b0010};
      vt[2] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000};
      vt[3] = '{1'b1, 2'd2, 4'b0000, 1'b1, 4'b0000};
      vt[4] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
      vt[5] = '{1'b0, 2'd3, 4'b0111, 1'b0, 4'b0000};
      vt[6] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010};
      m_v = 0; m_d = 0; m_ch = 0; m_cnt = 0; m_last = NCH - 1;
      reset = 1; mode = 1; sel = 0; in_data = 32'h44332211; in_valid = 4'b1111; out_ready = 1;
      tick();
      tick();
      reset = 0;
      for (int i = 0; i < 7; i++) begin
         mode = vt[i].mode; sel = vt[i].sel; in_valid = vt[i].valid; out_ready = vt[i].ordy;
         #1 chk($sformatf("vec%0d", i), 32'(in_ready), 32'(vt[i].exp_ready));
      end
      in_valid = 0;
      @(posedge clk);
      #1;
      out_ready = 1;
      mode = 0; sel = 2; in_valid = 4'b1111; in_data = 32'h11A52233;
      tick();
      chk("fixed_data", 32'(out_data), 32'hA5);
      chk("fixed_ch", 32'(out_ch), 32'd2);
      sel = 3; in_valid = 4'b0111;
      tick();
      chk("fixed_drain", 32'(out_valid), 32'd0);
      mode = 1; in_valid = 4'b1111; c0 = xfer_cnt;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_ch", 32'(out_ch), 32'(i % 4));
         chk("rr_valid", 32'(out_valid), 32'd1);
      end
      chk("rr_cnt", 32'(xfer_cnt - c0), 32'd8);
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("skip_ch", 32'(out_ch), (i % 2) ? 32'd3 : 32'd1);
      end
      in_valid = 4'b0001;
      tick();
      chk("skip_ch0", 32'(out_ch), 32'd0);
      in_valid = 4'b0010; in_data = 32'h00003C00;
      tick();
      chk("bp_load", 32'(out_data), 32'h3C);
      out_ready = 0; in_valid = 4'b1111; in_data = 32'h77665544; c0 = xfer_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", 32'(out_data), 32'h3C);
      end
      chk("bp_cnt", 32'(xfer_cnt), 32'(c0));
      out_ready = 1;
      tick();
      chk("bp_reload", 32'(out_ch), 32'd2);
      chk("bp_reload_data", 32'(out_data), 32'h66);
      c0 = xfer_cnt;
      for (int i = 0; i < 65536 - int'(c0); i++) tick();
      chk("wrap", 32'(xfer_cnt), 32'd0);
      chk("wrap_valid", 32'(out_valid), 32'd1);
      reset = 1;
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      reset = 0;
      tick();
      chk("rst_rr_ch0", 32'(out_ch), 32'd0);
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         mode = 1'($urandom);
         sel = 2'($urandom);
         in_data = $urandom;
         in_valid = 4'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
